// File: rtl/regfile_pkg.sv
// Shared register-file types and sizing for the datapath.
// Exports DATA_W, ADDR_W, NUM_REGS, word_t and regnum_t.
package regfile_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 8;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] regnum_t;

endpackage

// File: rtl/reg_ld.sv
// reg_ld: one load-enabled register with synchronous active-low clear.
// Ports: clk, rst_n (sync, active-low), ld_i (load), d_i (data), q_o (stored).
module reg_ld #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ld_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] val_q;
  logic [W-1:0] val_d;

  always_comb begin
    val_d = val_q;
    if (ld_i) val_d = d_i;
  end

  // Clear wins over load in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) val_q <= '0;
    else        val_q <= val_d;
  end

  assign q_o = val_q;

endmodule

// File: rtl/regfile.sv
// regfile: NUM_REGS x DATA_W register file, one sync write and one comb read port.
// Ports: clk, rst_n (sync, active-low), data_in, writenum, write, readnum, data_out.
// Option: define REGFILE_BYPASS_EN to forward data_in to data_out when
// a write targets the register being read in the same cycle.
module regfile
  import regfile_pkg::*;
#(
  parameter int DATA_W   = regfile_pkg::DATA_W,
  parameter int ADDR_W   = regfile_pkg::ADDR_W,
  parameter int NUM_REGS = regfile_pkg::NUM_REGS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W-1:0] writenum,
  input  logic              write,
  input  logic [ADDR_W-1:0] readnum,
  output logic [DATA_W-1:0] data_out
);

  if (NUM_REGS != (1 << ADDR_W)) begin : g_bad_cfg
    $error("regfile: NUM_REGS must equal 2**ADDR_W");
  end

  logic [NUM_REGS-1:0] ld_en;
  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [DATA_W-1:0]   rd_word;

  // One-hot decode of writenum, gated by write.
  always_comb begin
    ld_en = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      ld_en[i] = write && (writenum == ADDR_W'(i));
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    reg_ld #(
      .W(DATA_W)
    ) u_reg (
      .clk  (clk),
      .rst_n(rst_n),
      .ld_i (ld_en[g]),
      .d_i  (data_in),
      .q_o  (regs[g])
    );
  end

  assign rd_word = regs[readnum];

`ifdef REGFILE_BYPASS_EN
  // Write-through forwarding; suppressed while reset is asserted.
  logic byp;
  assign byp = rst_n && write && (writenum == readnum);
  assign data_out = byp ? data_in : rd_word;
`else
  assign data_out = rd_word;
`endif

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed scenarios plus random traffic
// compared against an array-based reference model.
module tb_regfile;

  logic        clk;
  logic        rst_n;
  logic [15:0] data_in;
  logic [2:0]  writenum;
  logic        write;
  logic [2:0]  readnum;
  logic [15:0] data_out;

  int n_cmp;
  int n_bad;

  logic [15:0] mdl [8];
  bit          byp_on;

  regfile dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .data_in (data_in),
    .writenum(writenum),
    .write   (write),
    .readnum (readnum),
    .data_out(data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // One clock: drive at negedge, check read before the edge,
  // then advance the model at the rising edge.
  task automatic cycle(input logic rs, input logic wr,
                       input logic [2:0] wn, input logic [15:0] din,
                       input logic [2:0] rn, input string tag);
    logic [15:0] exp;
    @(negedge clk);
    rst_n    = rs;
    write    = wr;
    writenum = wn;
    data_in  = din;
    readnum  = rn;
    #1;
    if (byp_on && rs && wr && wn == rn) exp = din;
    else exp = mdl[rn];
    chk(tag, data_out, exp);
    @(posedge clk);
    if (!rs) begin
      for (int i = 0; i < 8; i++) mdl[i] = 16'h0;
    end else if (wr) begin
      mdl[wn] = din;
    end
  endtask

  task automatic rd(input logic [2:0] rn, input string tag);
    cycle(1'b1, 1'b0, 3'd0, 16'hDEAD, rn, tag);
  endtask

  initial begin
    logic [15:0] vals [8];
    n_cmp = 0;
    n_bad = 0;
`ifdef REGFILE_BYPASS_EN
    byp_on = 1'b1;
`else
    byp_on = 1'b0;
`endif
    vals = '{16'd42, 16'd10, 16'd20, 16'd30,
             16'd35, 16'd15, 16'd8, 16'd5};
    rst_n    = 1'b0;
    write    = 1'b0;
    writenum = '0;
    data_in  = '0;
    readnum  = '0;
    @(posedge clk);
    @(posedge clk);
    for (int i = 0; i < 8; i++) mdl[i] = 16'h0;

    for (int k = 0; k < 8; k++) rd(3'(k), "rst_read");

    for (int k = 0; k < 8; k++)
      cycle(1'b1, 1'b1, 3'(k), vals[k], 3'((k + 1) % 8), "wr_all");
    for (int k = 0; k < 8; k++) begin
      rd(3'(k), "rd_all");
      chk("rd_all_abs", data_out, vals[k]);
    end

    cycle(1'b1, 1'b0, 3'd3, 16'hBEEF, 3'd3, "gate_pre");
    rd(3'd3, "gate_r3");
    chk("gate_abs", data_out, 16'd30);

    cycle(1'b1, 1'b1, 3'd5, 16'hFFFF, 3'd4, "ovr_ffff");
    rd(3'd5, "ovr_r5_ffff");
    cycle(1'b1, 1'b1, 3'd5, 16'h0001, 3'd0, "ovr_0001");
    rd(3'd5, "ovr_r5");
    chk("ovr_abs", data_out, 16'h0001);
    rd(3'd4, "ovr_r4");
    chk("ovr_r4_abs", data_out, 16'd35);

    cycle(1'b1, 1'b1, 3'd6, 16'h00AA, 3'd6, "byp_pre");
    chk("byp_abs", data_out, byp_on ? 16'h00AA : 16'd8);
    rd(3'd6, "byp_post");
    chk("byp_post_abs", data_out, 16'h00AA);

    cycle(1'b0, 1'b1, 3'd2, 16'h1234, 3'd2, "rstpri_pre");
    rd(3'd2, "rstpri_r2");
    chk("rstpri_abs", data_out, 16'h0000);
    rd(3'd6, "rstpri_r6");

    for (int n = 0; n < 300; n++) begin
      cycle(($urandom_range(0, 31) != 0),
            1'($urandom),
            3'($urandom),
            ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom),
            3'($urandom),
            "rand");
    end
    for (int k = 0; k < 8; k++) rd(3'(k), "final_rd");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
